// File: rtl/trigger_capture_seq.sv
// Multi-channel arm/trigger/capture sequencer in the ADC clock domain.
// Optional trigger timestamp counter enabled by defining TRIG_TIMESTAMP_EN.
module trigger_capture_seq #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned HOLDOFF_W = 12,
  parameter int unsigned EVENT_W   = 8,
  parameter int unsigned TS_W      = 32
) (
  input  logic                 clk,
  input  logic                 Reset_n,
  input  logic [NUM_CH-1:0]    trig_in,
  input  logic [NUM_CH-1:0]    ch_mask,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic                 manual_trigger,
  input  logic                 manual_reset,
  input  logic                 auto_reset,
  input  logic [CNT_W-1:0]     post_len,
  input  logic [HOLDOFF_W-1:0] holdoff,
  input  logic [EVENT_W-1:0]   num_events,
  input  logic                 wr_ready,
  output logic                 capture_en,
  output logic                 triggered_out,
  output logic                 comp_reset,
  output logic                 armed_out,
  output logic                 done,
  output logic [NUM_CH-1:0]    trig_source,
  output logic [EVENT_W-1:0]   event_count,
  output logic [7:0]           missed_count,
  output logic [TS_W-1:0]      trig_timestamp
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_CAPTURE, S_WAIT_RESET, S_HOLDOFF, S_DONE
  } state_t;

  state_t               state_q;
  logic [NUM_CH-1:0]    trig_prev_q, trig_source_q, fire_vec_d;
  logic [CNT_W-1:0]     win_cnt_q, win_len_d;
  logic [HOLDOFF_W-1:0] hold_cnt_q, hold_len_d;
  logic [EVENT_W-1:0]   event_count_q, event_inc_d;
  logic [7:0]           missed_q;
  logic                 capture_q, triggered_q, comp_reset_q, armed_q, done_q;
  logic                 trig_any_d, take_trig_d;

  always_comb begin
    fire_vec_d  = trig_in & ~trig_prev_q & ch_mask;
    trig_any_d  = (|fire_vec_d) | manual_trigger;
    take_trig_d = Reset_n && !disarm && !arm && (state_q == S_ARMED)
                  && trig_any_d && wr_ready;
    win_len_d   = (post_len == '0) ? CNT_W'(1) : post_len;
    hold_len_d  = (holdoff == '0) ? HOLDOFF_W'(1) : holdoff;
    event_inc_d = (event_count_q == '1) ? event_count_q : event_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    trig_prev_q <= trig_in;
    if (!Reset_n) begin
      state_q       <= S_IDLE;
      win_cnt_q     <= '0;
      hold_cnt_q    <= '0;
      event_count_q <= '0;
      missed_q      <= '0;
      trig_source_q <= '0;
      capture_q     <= 1'b0;
      triggered_q   <= 1'b0;
      comp_reset_q  <= 1'b1;
      armed_q       <= 1'b0;
      done_q        <= 1'b0;
    end else if (disarm) begin
      state_q      <= S_IDLE;
      capture_q    <= 1'b0;
      triggered_q  <= 1'b0;
      comp_reset_q <= 1'b1;
      armed_q      <= 1'b0;
      done_q       <= 1'b0;
    end else if (arm) begin
      state_q       <= S_ARMED;
      event_count_q <= '0;
      missed_q      <= '0;
      trig_source_q <= '0;
      capture_q     <= 1'b0;
      triggered_q   <= 1'b0;
      comp_reset_q  <= 1'b0;
      armed_q       <= 1'b1;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (trig_any_d && wr_ready) begin
            state_q       <= S_CAPTURE;
            trig_source_q <= fire_vec_d;
            win_cnt_q     <= win_len_d;
            capture_q     <= 1'b1;
            triggered_q   <= 1'b1;
            armed_q       <= 1'b0;
          end else if (trig_any_d && missed_q != 8'hFF) begin
            missed_q <= missed_q + 1'b1;
          end
        end
        S_CAPTURE: begin
          if (win_cnt_q == CNT_W'(1)) begin
            capture_q     <= 1'b0;
            event_count_q <= event_inc_d;
            if (num_events != '0 && event_inc_d == num_events) begin
              state_q      <= S_DONE;
              done_q       <= 1'b1;
              comp_reset_q <= 1'b1;
            end else if (auto_reset) begin
              state_q      <= S_HOLDOFF;
              hold_cnt_q   <= hold_len_d;
              comp_reset_q <= 1'b1;
            end else begin
              state_q <= S_WAIT_RESET;
            end
          end else begin
            win_cnt_q <= win_cnt_q - 1'b1;
          end
        end
        S_WAIT_RESET: begin
          if (manual_reset) begin
            state_q      <= S_HOLDOFF;
            hold_cnt_q   <= hold_len_d;
            comp_reset_q <= 1'b1;
          end
        end
        S_HOLDOFF: begin
          if (hold_cnt_q == HOLDOFF_W'(1)) begin
            state_q      <= S_ARMED;
            comp_reset_q <= 1'b0;
            triggered_q  <= 1'b0;
            armed_q      <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TRIG_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, trig_ts_q;

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      ts_q      <= '0;
      trig_ts_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (take_trig_d) trig_ts_q <= ts_q;
    end
  end

  assign trig_timestamp = trig_ts_q;
`else
  logic unused_take_trig;
  assign unused_take_trig = take_trig_d;
  assign trig_timestamp   = '0;
`endif

  assign capture_en    = capture_q;
  assign triggered_out = triggered_q;
  assign comp_reset    = comp_reset_q;
  assign armed_out     = armed_q;
  assign done          = done_q;
  assign trig_source   = trig_source_q;
  assign event_count   = event_count_q;
  assign missed_count  = missed_q;

endmodule

// File: tb/tb_trigger_capture_seq.sv
// Directed self-checking bench for trigger_capture_seq (default 4-channel build).
module tb_trigger_capture_seq;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic [3:0]  trig_in, ch_mask;
  logic        arm, disarm, manual_trigger, manual_reset, auto_reset, wr_ready;
  logic [15:0] post_len;
  logic [11:0] holdoff;
  logic [7:0]  num_events;
  logic        capture_en, triggered_out, comp_reset, armed_out, done;
  logic [3:0]  trig_source;
  logic [7:0]  event_count, missed_count;
  logic [31:0] trig_timestamp;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cnt;

  trigger_capture_seq #(.NUM_CH(4), .CNT_W(16), .HOLDOFF_W(12), .EVENT_W(8), .TS_W(32)) dut (
    .clk(clk), .Reset_n(Reset_n), .trig_in(trig_in), .ch_mask(ch_mask),
    .arm(arm), .disarm(disarm), .manual_trigger(manual_trigger),
    .manual_reset(manual_reset), .auto_reset(auto_reset), .post_len(post_len),
    .holdoff(holdoff), .num_events(num_events), .wr_ready(wr_ready),
    .capture_en(capture_en), .triggered_out(triggered_out), .comp_reset(comp_reset),
    .armed_out(armed_out), .done(done), .trig_source(trig_source),
    .event_count(event_count), .missed_count(missed_count),
    .trig_timestamp(trig_timestamp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    Reset_n = 1'b0; trig_in = '0; ch_mask = 4'hF; arm = 0; disarm = 0;
    manual_trigger = 0; manual_reset = 0; auto_reset = 0; wr_ready = 1;
    post_len = 16'd5; holdoff = 12'd0; num_events = 8'd0;
    tick(2);
    check("rst_cap", capture_en, 0);
    check("rst_comp", comp_reset, 1);
    check("rst_armed", armed_out, 0);
    check("rst_done", done, 0);
    check("rst_evt", event_count, 0);
    Reset_n = 1'b1;

    // single masked channel, 5-cycle window, manual re-arm
    ch_mask = 4'b0010;
    arm = 1; tick(); arm = 0;
    check("arm_armed", armed_out, 1);
    check("arm_comp", comp_reset, 0);
    trig_in = 4'b0010; tick();
    check("t2_trig", triggered_out, 1);
    check("t2_src", trig_source, 4'b0010);
    cnt = capture_en;
    for (int unsigned i = 0; i < 8; i++) begin tick(); cnt += capture_en; end
    check("t2_winlen", cnt, 5);
    check("t2_evt", event_count, 1);
    check("t2_wait_trig", triggered_out, 1);
    check("t2_wait_comp", comp_reset, 0);
    manual_reset = 1; tick(); manual_reset = 0;
    check("t2_hold_comp", comp_reset, 1);
    tick();
    check("t2_rearm", armed_out, 1);
    check("t2_rearm_trig", triggered_out, 0);

    // masked channel ignored, stuck-high channel ignored until it re-rises
    ch_mask = 4'b0001;
    trig_in = 4'b0110; tick(3);
    check("t3_masked", capture_en, 0);
    check("t3_masked_arm", armed_out, 1);
    disarm = 1; tick(); disarm = 0;
    check("dis_comp", comp_reset, 1);
    check("dis_armed", armed_out, 0);
    trig_in = 4'b0001; tick();
    arm = 1; tick(); arm = 0;
    tick(3);
    check("t3_stuck", capture_en, 0);
    trig_in = 4'b0000; tick();
    trig_in = 4'b0001; tick();
    check("t3_rise_cap", capture_en, 1);
    check("t3_rise_src", trig_source, 4'b0001);
    tick(2);
    disarm = 1; tick(); disarm = 0;
    check("t6_dis_cap", capture_en, 0);
    check("t6_dis_comp", comp_reset, 1);

    // auto re-arm with holdoff, event limit
    ch_mask = 4'hF; auto_reset = 1; holdoff = 12'd3; num_events = 8'd2; post_len = 16'd2;
    trig_in = 4'b0000;
    arm = 1; tick(); arm = 0;
    trig_in = 4'b0100; tick();
    check("t4_cap1", capture_en, 1);
    tick(2);
    check("t4_evt1", event_count, 1);
    cnt = comp_reset;
    for (int unsigned i = 0; i < 5; i++) begin tick(); cnt += comp_reset; end
    check("t4_holdoff", cnt, 3);
    check("t4_rearm", armed_out, 1);
    trig_in = 4'b0000; tick();
    trig_in = 4'b1000; tick(3);
    check("t4_done", done, 1);
    check("t4_evt2", event_count, 2);
    check("t4_done_comp", comp_reset, 1);
    check("t4_done_trig", triggered_out, 1);
    trig_in = 4'b0000; tick();
    trig_in = 4'b0001; tick(2);
    check("t4_third_cap", capture_en, 0);
    check("t4_third_evt", event_count, 2);

    // storage busy: missed triggers, then manual 1-cycle window
    arm = 1; tick(); arm = 0;
    check("t5_arm_done", done, 0);
    check("t5_arm_evt", event_count, 0);
    wr_ready = 0;
    trig_in = 4'b0000; tick(); trig_in = 4'b0010; tick();
    trig_in = 4'b0000; tick(); trig_in = 4'b0100; tick();
    trig_in = 4'b0000; tick(); trig_in = 4'b1000; tick();
    check("t5_missed", missed_count, 3);
    check("t5_nocap", capture_en, 0);
    wr_ready = 1; post_len = 16'd0;
    manual_trigger = 1; tick(); manual_trigger = 0;
    check("t5_man_cap", capture_en, 1);
    check("t5_man_src", trig_source, 0);
    tick();
    check("t5_len0_end", capture_en, 0);
    check("t5_evt", event_count, 1);

    // reset in the middle of a window
    tick(4);
    post_len = 16'd5;
    trig_in = 4'b0000; tick(); trig_in = 4'b0001; tick();
    check("t1_pre_cap", capture_en, 1);
    tick();
    Reset_n = 0; tick(); Reset_n = 1;
    check("t1_cap", capture_en, 0);
    check("t1_comp", comp_reset, 1);
    check("t1_evt", event_count, 0);
    check("t1_missed", missed_count, 0);
    check("t1_src", trig_source, 0);

    // trigger on the 100th edge after reset release
    arm = 1; trig_in = 4'b0000; tick(); arm = 0;
    tick(98);
    trig_in = 4'b0001; tick();
    check("t6_cap", capture_en, 1);
`ifdef TRIG_TIMESTAMP_EN
    check("t6_ts", trig_timestamp, 32'd99);
`else
    check("t6_ts", trig_timestamp, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
